// File: rtl/pattern_detector_automate.sv
// pattern_detector_automate
//   Sequence-detecting automaton. Watches a stream of DATA_WIDTH-bit symbols
//   and flags every occurrence of PATTERN (SEQ_LEN symbols, symbol 0 first,
//   symbol k at bits [k*DATA_WIDTH +: DATA_WIDTH]). Supports Mealy or
//   registered Moore output, overlapping or restart-after-match detection,
//   and a saturating match counter.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high
//   a            incoming symbol
//   a_valid      symbol on a is consumed this cycle
//   clear_count  synchronous clear of match_count (a same-cycle hit counts as 1)
//   match        pattern-complete flag (same cycle if MEALY=1, next cycle if 0)
//   state        number of pattern symbols currently matched (0..SEQ_LEN-1)
//   match_count  saturating number of matches since reset/clear
module pattern_detector_automate #(
   parameter int unsigned DATA_WIDTH  = 2,
   parameter int unsigned SEQ_LEN     = 4,
   parameter logic [SEQ_LEN*DATA_WIDTH-1:0] PATTERN = {2'b11, 2'b10, 2'b01, 2'b00},
   parameter bit          MEALY       = 1'b1,
   parameter bit          OVERLAP     = 1'b1,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      a,
   input  logic                       a_valid,
   input  logic                       clear_count,
   output logic                       match,
   output logic [$clog2(SEQ_LEN)-1:0] state,
   output logic [COUNT_WIDTH-1:0]     match_count
);

   localparam int unsigned SW    = $clog2(SEQ_LEN);
   localparam int unsigned NSYM  = 1 << DATA_WIDTH;
   localparam int unsigned TBL_W = SEQ_LEN * NSYM * SW;

   // Full transition table, entry (s, c) at index s*NSYM + c: the longest
   // pattern prefix that is a suffix of (prefix[0..s-1], c). The length is
   // capped at SEQ_LEN-1, so the completing entry already holds the failure
   // value of the whole pattern, which is the overlapping-restart state.
   function automatic logic [TBL_W-1:0] build_next();
      logic [TBL_W-1:0]      tbl;
      logic [DATA_WIDTH-1:0] tj;
      int unsigned           best;
      int unsigned           kmax;
      int unsigned           idx;
      logic                  ok;
      tbl = '0;
      for (int unsigned s = 0; s < SEQ_LEN; s++) begin
         for (int unsigned c = 0; c < NSYM; c++) begin
            best = 0;
            kmax = (s + 1 < SEQ_LEN) ? s + 1 : SEQ_LEN - 1;
            for (int unsigned k = 1; k <= kmax; k++) begin
               ok = 1'b1;
               for (int unsigned j = 0; j < k; j++) begin
                  idx = s + 1 - k + j;
                  tj  = (idx < s) ? PATTERN[idx*DATA_WIDTH +: DATA_WIDTH]
                                  : DATA_WIDTH'(c);
                  if (tj != PATTERN[j*DATA_WIDTH +: DATA_WIDTH]) ok = 1'b0;
               end
               if (ok) best = k;
            end
            tbl[(s*NSYM + c)*SW +: SW] = SW'(best);
         end
      end
      return tbl;
   endfunction

   localparam logic [TBL_W-1:0] NXT = build_next();

   logic [SW-1:0]            s_q, s_d, s_tbl;
   logic [SW+DATA_WIDTH-1:0] tbl_idx;
   logic                     hit;
   logic                     match_q;
   logic [COUNT_WIDTH-1:0]   count_q;

   assign tbl_idx = {s_q, a};
   assign s_tbl   = NXT[tbl_idx*SW +: SW];

   always_comb begin
      s_d = s_q;
      hit = a_valid && (s_q == SW'(SEQ_LEN-1)) &&
            (a == PATTERN[(SEQ_LEN-1)*DATA_WIDTH +: DATA_WIDTH]);
      if (a_valid) begin
         if (hit && !OVERLAP) s_d = '0;
         else                 s_d = s_tbl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) s_q <= '0;
      else       s_q <= s_d;
   end

   always_ff @(posedge clk) begin
      if (reset) match_q <= 1'b0;
      else       match_q <= hit;
   end

   always_ff @(posedge clk) begin
      if (reset)                        count_q <= '0;
      else if (clear_count)             count_q <= hit ? COUNT_WIDTH'(1) : '0;
      else if (hit && (count_q != '1))  count_q <= count_q + COUNT_WIDTH'(1);
   end

   assign match       = MEALY ? hit : match_q;
   assign state       = s_q;
   assign match_count = count_q;

endmodule

// File: doc/pattern_detector_automate.md
# pattern_detector_automate

Parametrised sequence-detecting automaton for the SyncAutomates lab set. It watches a stream of DATA_WIDTH-bit symbols and flags every occurrence of a compile-time pattern of SEQ_LEN symbols. The match output is produced in Mealy form (same cycle) or Moore form (registered) according to a parameter. Overlapping-match detection, a symbol-valid qualifier and a saturating match counter are all built in. It generalises the lab's 2-bit Mealy automaton and is the block the lab testbenches instantiate for detector exercises.

## Interface
Parameters:
- DATA_WIDTH, 2, symbol width in bits (>=1)
- SEQ_LEN, 4, pattern length in symbols (>=2)
- PATTERN, {2'b11,2'b10,2'b01,2'b00}, SEQ_LEN*DATA_WIDTH bits; symbol k at bits [k*DATA_WIDTH +: DATA_WIDTH]; symbol 0 is expected first
- MEALY, 1, 1 = Mealy output, 0 = Moore output
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = restart after each match
- COUNT_WIDTH, 8, match counter width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- a  input  DATA_WIDTH  incoming symbol
- a_valid  input  1  symbol on a is consumed this cycle
- clear_count  input  1  synchronous clear of match_count
- match  output  1  pattern-complete flag
- state  output  clog2(SEQ_LEN)  number of pattern symbols currently matched (0..SEQ_LEN-1)
- match_count  output  COUNT_WIDTH  saturating number of matches since reset/clear

## Operation
- Internal state S in 0..SEQ_LEN-1 = length of the longest pattern prefix that is a suffix of the consumed stream. S drives the state port directly.
- hit = a_valid && (S == SEQ_LEN-1) && (a == PATTERN symbol SEQ_LEN-1).
- On a_valid with no hit: S_next = length of the longest prefix of PATTERN that is a suffix of (prefix[0..S-1] followed by a). This is the KMP fallback and is never simply 0 when a partial re-match exists. The fallback table is computed at elaboration with a constant function; no runtime table.
- On hit with OVERLAP=1: S_next = longest proper prefix of PATTERN that is also a suffix of the full PATTERN (the failure value of SEQ_LEN).
- On hit with OVERLAP=0: S_next = 0.
- a_valid=0: S holds, hit=0.
- MEALY=1: match = hit, combinational from a, a_valid and S.
- MEALY=0: match is a register loaded with hit every cycle, so it is high exactly one cycle after each hit.
- match_count priority: reset, then clear_count, then increment.
  - clear_count && hit: count becomes 1.
  - clear_count alone: count becomes 0.
  - hit alone: count increments, saturating at all-ones. It never wraps.
- Reset values: S=0, state=0, match=0 (Moore register 0; the Mealy output is 0 because S=0), match_count=0.
- Reset asserted mid-sequence discards the partial match. The symbol presented during the reset cycle is ignored, even if a_valid=1.

## Timing
- Mealy latency: match is high in the same cycle as the completing symbol. match_count reflects the match at the next edge.
- Moore latency: match is high one cycle after the completing symbol, for exactly one cycle per hit. The counter updates at the same edge at which Moore match rises.
- Back-to-back hits (possible with OVERLAP=1 and a self-overlapping pattern, or with SEQ_LEN=2 and a repeating pattern) produce consecutive match pulses with no gap.
- Throughput is one symbol per cycle. There is no backpressure.
- state updates one edge after a valid symbol.

## Test plan
- Defaults, reset held 2 cycles, then a_valid=1 with a = 0,1,2,3 -> state 0,1,2,3 on successive cycles; match=1 in the cycle a=3 (Mealy); match_count=1 afterwards.
- Defaults with stream 0,1,0,1,2,3 -> state goes 0,1,2 then falls back to 1 at the second 0 (not to 0); exactly one match, on the final symbol.
- DATA_WIDTH=1, SEQ_LEN=3, PATTERN=101, stream 1,0,1,0,1 -> OVERLAP=1 gives 2 matches (symbols 3 and 5); OVERLAP=0 gives 1 match; MEALY=0 shows each pulse delayed exactly one cycle.
- Defaults, stream 0,1,2 with a_valid dropped for 3 cycles before 3 -> state holds at 3, match stays 0 during the gap, match fires on 3; then reset asserted after 0,1 -> state=0, match=0, count=0 next cycle.
- COUNT_WIDTH=2, drive 5 full patterns -> match_count reads 1,2,3,3,3; clear_count asserted in the same cycle as a hit -> count=1; clear_count alone -> count=0.
